// File: rtl/ghash_mult_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ghash_mult_sched
// Description : Sequences a shared external GF(2^128) multiplier/reducer
//               through the GHASH recurrence Y_i = (Y_{i-1} ^ X_i) * H.
//               Owns the accumulator, the H register, operand issue and
//               result-latency tracking; emits the final Y of a frame as tag.
// Revision    : 1.0 - initial release
// ============================================================================
module ghash_mult_sched #(
    parameter int NB_DATA     = 128,
    parameter int MUL_LATENCY = 1,
    parameter int NB_CNT      = 16
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic [NB_DATA-1:0] i_h_key,
    input  logic               i_h_load,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    input  logic               i_sof,
    input  logic               i_eof,
    output logic               o_ready,
    output logic [NB_DATA-1:0] o_mul_x,
    output logic [NB_DATA-1:0] o_mul_y,
    output logic               o_mul_valid,
    input  logic [NB_DATA-1:0] i_mul_z,
    output logic [NB_DATA-1:0] o_tag,
    output logic               o_tag_valid,
    output logic [NB_CNT-1:0]  o_block_cnt
);

    // The operand registers act as the first latency stage: the product is
    // sampled in the cycle in which the latency counter reaches one, so a new
    // block is accepted every MUL_LATENCY+1 cycles.
    localparam int                 c_LAT_W    = (MUL_LATENCY < 2) ? 1 : $clog2(MUL_LATENCY + 1);
    localparam logic [c_LAT_W-1:0] c_LAT_INIT = c_LAT_W'(MUL_LATENCY);
    localparam logic [c_LAT_W-1:0] c_LAT_ONE  = c_LAT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_xfer;
    logic                 w_sample;

    logic [NB_DATA-1:0]   r_acc;
    logic [NB_DATA-1:0]   r_h;
    logic                 r_h_loaded;
    logic                 r_eof;
    logic [c_LAT_W-1:0]   r_lat;
    logic [NB_DATA-1:0]   r_mul_x;
    logic [NB_DATA-1:0]   r_mul_y;
    logic [NB_DATA-1:0]   r_tag;
    logic                 r_tag_valid;
    logic [NB_CNT-1:0]    r_block_cnt;

    assign w_xfer      = o_ready & i_valid;
    assign o_mul_x     = r_mul_x;
    assign o_mul_y     = r_mul_y;
    assign o_tag       = r_tag;
    assign o_tag_valid = r_tag_valid;
    assign o_block_cnt = r_block_cnt;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the handshake / strobe / product-sample controls.
    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        o_mul_valid  = 1'b0;
        w_sample     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = r_h_loaded;
                if (i_valid && r_h_loaded) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_mul_valid = 1'b1;
                if (r_lat == c_LAT_ONE) begin
                    w_sample     = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_lat == c_LAT_ONE) begin
                    w_sample     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: H register, operand issue, latency count, accumulator and tag.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_acc       <= '0;
            r_h         <= '0;
            r_h_loaded  <= 1'b0;
            r_eof       <= 1'b0;
            r_lat       <= '0;
            r_mul_x     <= '0;
            r_mul_y     <= '0;
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
            r_block_cnt <= '0;
        end else begin
            r_tag_valid <= 1'b0;

            // H may only change between blocks; a same-cycle transfer still
            // captures the previous H below.
            if ((r_state == ST_IDLE) && i_h_load) begin
                r_h        <= i_h_key;
                r_h_loaded <= 1'b1;
            end

            if (w_xfer) begin
                r_mul_x <= (i_sof ? {NB_DATA{1'b0}} : r_acc) ^ i_data;
                r_mul_y <= r_h;
                r_eof   <= i_eof;
                r_lat   <= c_LAT_INIT;
                if (i_sof) begin
                    r_block_cnt <= NB_CNT'(1);
                end else if (r_block_cnt != {NB_CNT{1'b1}}) begin
                    r_block_cnt <= r_block_cnt + NB_CNT'(1);
                end
            end

            if (r_state != ST_IDLE) begin
                r_lat <= r_lat - c_LAT_ONE;
            end

            // Closing a frame clears the accumulator so an unflagged next
            // block naturally starts a fresh hash.
            if (w_sample) begin
                if (r_eof) begin
                    r_tag       <= i_mul_z;
                    r_tag_valid <= 1'b1;
                    r_acc       <= '0;
                end else begin
                    r_acc       <= i_mul_z;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ghash_mult_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ghash_mult_sched
// Description : Scoreboard bench for ghash_mult_sched with a 3-cycle
//               multiplier model (identity or true GF(2^128) product).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ghash_mult_sched;

    localparam int NB  = 128;
    localparam int LAT = 3;
    localparam int NC  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] h_key;
    logic          h_load;
    logic [NB-1:0] data;
    logic          valid;
    logic          sof;
    logic          eof;
    logic          ready;
    logic [NB-1:0] mul_x;
    logic [NB-1:0] mul_y;
    logic          mul_valid;
    logic [NB-1:0] mul_z;
    logic [NB-1:0] tag;
    logic          tag_valid;
    logic [NC-1:0] block_cnt;

    always #5 clk = ~clk;

    ghash_mult_sched #(
        .NB_DATA     (NB),
        .MUL_LATENCY (LAT),
        .NB_CNT      (NC)
    ) u_dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_h_key     (h_key),
        .i_h_load    (h_load),
        .i_data      (data),
        .i_valid     (valid),
        .i_sof       (sof),
        .i_eof       (eof),
        .o_ready     (ready),
        .o_mul_x     (mul_x),
        .o_mul_y     (mul_y),
        .o_mul_valid (mul_valid),
        .i_mul_z     (mul_z),
        .o_tag       (tag),
        .o_tag_valid (tag_valid),
        .o_block_cnt (block_cnt)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // GCM bit-reflected multiply in GF(2^128).
    function automatic logic [NB-1:0] gf_mult(input logic [NB-1:0] x, input logic [NB-1:0] y);
        logic [NB-1:0] z;
        logic [NB-1:0] v;
        z = '0;
        v = y;
        for (int i = 0; i < NB; i++) begin
            if (x[NB-1-i]) z = z ^ v;
            if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
            else      v = v >> 1;
        end
        return z;
    endfunction

    function automatic logic [NB-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Multiplier model: product formed from the held operands, then two
    // pipeline stages; outside its valid slot the result is poisoned.
    bit            use_gf = 1'b0;
    logic [NB-1:0] mz0;
    logic [NB-1:0] mz1 = '0;
    logic [NB-1:0] mz2 = '0;
    logic          mv1 = 1'b0;
    logic          mv2 = 1'b0;

    always_comb mz0 = use_gf ? gf_mult(mul_x, mul_y) : mul_x;

    always @(posedge clk) begin
        mz1 <= mz0;
        mv1 <= mul_valid;
        mz2 <= mz1;
        mv2 <= mv1;
    end

    assign mul_z = mv2 ? mz2 : {4{32'hdeadbeef}};

    // Scoreboard and reference state.
    typedef struct {
        logic [NB-1:0] tag;
        logic [NC-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [NB-1:0] m_h   = '0;
    logic [NB-1:0] m_acc = '0;
    logic [NC-1:0] m_cnt = '0;
    int            cyc   = 0;
    int            last_xfer = -1;
    logic          prev_tv = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tag_valid) begin
            chk("tag_pulse", prev_tv, 0);
            if (sb.size() == 0) begin
                chk("tag_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("tag", tag, mon_e.tag);
                chk("tag_cnt", block_cnt, mon_e.cnt);
            end
        end
        prev_tv = tag_valid;
    end

    task automatic send(input logic [NB-1:0] x, input bit s, input bit e, input bit hold);
        int            n;
        logic [NB-1:0] op;
        logic [NB-1:0] z;
        logic [NB-1:0] ey;
        n     = 0;
        data  = x;
        sof   = s;
        eof   = e;
        valid = 1'b1;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            chk("ready_timeout", 0, 1);
            valid = 1'b0;
            return;
        end
        chk("mv_idle", mul_valid, 0);
        if (hold && last_xfer >= 0) chk("xfer_gap", cyc - last_xfer, LAT + 1);
        last_xfer = hold ? cyc : -1;
        op    = (s ? '0 : m_acc) ^ x;
        z     = use_gf ? gf_mult(op, m_h) : op;
        ey    = m_h;
        m_cnt = s ? NC'(1) : ((m_cnt == '1) ? m_cnt : m_cnt + NC'(1));
        if (e) begin
            sb.push_back('{z, m_cnt});
            m_acc = '0;
        end else begin
            m_acc = z;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            valid = 1'b0;
            sof   = 1'b0;
            eof   = 1'b0;
        end
        @(negedge clk);
        chk("mul_valid", mul_valid, 1);
        chk("mul_x", mul_x, op);
        chk("mul_y", mul_y, ey);
    endtask

    task automatic load_h(input logic [NB-1:0] k);
        repeat (LAT + 2) @(posedge clk);
        #1;
        h_key  = k;
        h_load = 1'b1;
        @(posedge clk);
        #1;
        h_load = 1'b0;
        m_h    = k;
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_ready"}, ready, 0);
        chk({pfx, "_mul_valid"}, mul_valid, 0);
        chk({pfx, "_mul_x"}, mul_x, 0);
        chk({pfx, "_mul_y"}, mul_y, 0);
        chk({pfx, "_tag"}, tag, 0);
        chk({pfx, "_tag_valid"}, tag_valid, 0);
        chk({pfx, "_cnt"}, block_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] h1;
        logic [NB-1:0] h2;
        int            seen_ready;
        int            nb;

        rst_n  = 1'b0;
        h_key  = '0;
        h_load = 1'b0;
        data   = '0;
        valid  = 1'b0;
        sof    = 1'b0;
        eof    = 1'b0;
        #23;
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // No H loaded: block source is never accepted.
        seen_ready = 0;
        valid = 1'b1;
        data  = rand128();
        sof   = 1'b1;
        eof   = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (ready || mul_valid) seen_ready++;
        end
        valid = 1'b0;
        sof   = 1'b0;
        eof   = 1'b0;
        chk("no_h_ready", seen_ready, 0);
        chk("no_h_cnt", block_cnt, 0);

        // Three-block frame with identity multiplier: tag 0x07, count 3.
        load_h(rand128());
        send(128'h1, 1, 0, 0);
        send(128'h2, 0, 0, 0);
        send(128'h4, 0, 1, 0);
        repeat (8) @(posedge clk);

        // Back-to-back blocks with valid held high.
        last_xfer = -1;
        send(rand128(), 1, 0, 1);
        send(rand128(), 0, 0, 1);
        send(rand128(), 0, 0, 1);
        send(rand128(), 0, 1, 1);
        valid = 1'b0;
        sof   = 1'b0;
        eof   = 1'b0;
        last_xfer = -1;

        // H load during WAIT is ignored; in IDLE it takes effect next issue.
        h1 = rand128();
        h2 = rand128();
        load_h(h1);
        send(rand128(), 1, 0, 0);
        @(posedge clk);
        #1;
        h_key  = h2;
        h_load = 1'b1;
        @(posedge clk);
        #1;
        h_load = 1'b0;
        send(rand128(), 0, 0, 0);
        load_h(h2);
        chk("mul_y_hold", mul_y, h1);
        send(rand128(), 0, 1, 0);
        repeat (8) @(posedge clk);

        // Reset while block 2 of a frame waits on the multiplier.
        send(rand128(), 1, 0, 0);
        send(rand128(), 0, 1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        sb.delete();
        m_h   = '0;
        m_acc = '0;
        m_cnt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        load_h(rand128());
        send(128'h5, 1, 1, 0);
        repeat (8) @(posedge clk);

        // Random frames against the GHASH reference.
        use_gf = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            if (f % 50 == 0) load_h(rand128());
            nb = $urandom_range(1, 20);
            for (int b = 0; b < nb; b++) begin
                send(rand128(), (b == 0) && ($urandom_range(0, 9) != 0), b == nb - 1, 0);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        repeat (10) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
